cva6_axi_mux2: RTL and testbench

//  Shares the single outgoing core AXI4 port between two masters: the atomics-filtered core port (s0) and a debug/DMA port (s1).

---
 rtl/cva6_axi_mux2.sv | 234 +++++++++++++++++++++++
 tb/tb_cva6_axi_mux2.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_axi_mux2.sv
// cva6_axi_mux2: shares one outgoing AXI4 port between the atomics-filtered
// core port (master 0) and the debug/DMA port (master 1). AW and AR each pass
// through a round-robin arbiter into a one-entry output register, and the
// winning master's index is prepended to the ID. W beats follow AW acceptance
// order through a small source FIFO. B and R are steered back by the ID MSB.
// Per-master outstanding counters throttle AW/AR acceptance.
module cva6_axi_mux2 #(
  parameter int unsigned ID_W     = 4,
  parameter int unsigned AW_PLD_W = 80,
  parameter int unsigned AR_PLD_W = 74,
  parameter int unsigned W_PLD_W  = 73,
  parameter int unsigned B_PLD_W  = 2,
  parameter int unsigned R_PLD_W  = 66,
  parameter int unsigned W_FIFO_D = 4,
  parameter int unsigned MAX_OUT  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // slave side (two masters)
  input  logic [1:0]            s_aw_valid,
  output logic [1:0]            s_aw_ready,
  input  logic [2*ID_W-1:0]     s_aw_id,
  input  logic [2*AW_PLD_W-1:0] s_aw_pld,
  input  logic [1:0]            s_w_valid,
  input  logic [1:0]            s_w_last,
  output logic [1:0]            s_w_ready,
  input  logic [2*W_PLD_W-1:0]  s_w_pld,
  output logic [1:0]            s_b_valid,
  input  logic [1:0]            s_b_ready,
  output logic [ID_W-1:0]       s_b_id,
  output logic [B_PLD_W-1:0]    s_b_pld,
  input  logic [1:0]            s_ar_valid,
  output logic [1:0]            s_ar_ready,
  input  logic [2*ID_W-1:0]     s_ar_id,
  input  logic [2*AR_PLD_W-1:0] s_ar_pld,
  output logic [1:0]            s_r_valid,
  input  logic [1:0]            s_r_ready,
  output logic [ID_W-1:0]       s_r_id,
  output logic [R_PLD_W-1:0]    s_r_pld,
  output logic                  s_r_last,
  // master side (single downstream port)
  output logic                  m_aw_valid,
  input  logic                  m_aw_ready,
  output logic [ID_W:0]         m_aw_id,
  output logic [AW_PLD_W-1:0]   m_aw_pld,
  output logic                  m_w_valid,
  input  logic                  m_w_ready,
  output logic                  m_w_last,
  output logic [W_PLD_W-1:0]    m_w_pld,
  input  logic                  m_b_valid,
  output logic                  m_b_ready,
  input  logic [ID_W:0]         m_b_id,
  input  logic [B_PLD_W-1:0]    m_b_pld,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ID_W:0]         m_ar_id,
  output logic [AR_PLD_W-1:0]   m_ar_pld,
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [ID_W:0]         m_r_id,
  input  logic [R_PLD_W-1:0]    m_r_pld,
  input  logic                  m_r_last
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = $clog2(W_FIFO_D);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  // Two-way round robin: a lone requester wins, a tie goes to the pointer.
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic ptr);
    logic [1:0] grant;
    grant = elig;
    if (elig == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    return grant;
  endfunction

  // Outstanding counters, W FIFO and request-stage state
  logic [1:0][CNT_W-1:0] r_wcnt, r_rcnt;
  logic [W_FIFO_D-1:0]   r_fifo;
  logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
  logic                  r_aw_valid, r_aw_src, r_aw_ptr;
  logic [ID_W-1:0]       r_aw_id;
  logic [AW_PLD_W-1:0]   r_aw_pld;
  logic                  r_ar_valid, r_ar_src, r_ar_ptr;
  logic [ID_W-1:0]       r_ar_id;
  logic [AR_PLD_W-1:0]   r_ar_pld;

  logic [1:0] w_aw_elig, w_ar_elig, w_aw_hs, w_ar_hs, w_b_hs, w_r_done;
  logic       w_fifo_empty, w_fifo_full, w_head, w_push, w_pop;
  logic       w_b_src, w_r_src;

  // Eligibility: a master may request only while under its outstanding limit;
  // AW additionally needs room in the W routing FIFO.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_aw_elig = '0;
    w_ar_elig = '0;
    for (int i = 0; i < 2; i++) begin
      // NOTE: blocking '=' in combinational logic; sequential state uses '<='.
      w_aw_elig[i] = s_aw_valid[i] && (r_wcnt[i] < CNT_MAX) && !w_fifo_full;
      w_ar_elig[i] = s_ar_valid[i] && (r_rcnt[i] < CNT_MAX);
    end
  end

  // A grant turns into ready only when the output register is free this cycle.
  assign s_aw_ready = (!r_aw_valid || m_aw_ready) ? rr_pick(w_aw_elig, r_aw_ptr) : 2'b00;
  assign s_ar_ready = (!r_ar_valid || m_ar_ready) ? rr_pick(w_ar_elig, r_ar_ptr) : 2'b00;
  assign w_aw_hs    = s_aw_valid & s_aw_ready;
  assign w_ar_hs    = s_ar_valid & s_ar_ready;

  assign m_aw_valid = r_aw_valid;
  assign m_aw_id    = {r_aw_src, r_aw_id};
  assign m_aw_pld   = r_aw_pld;
  assign m_ar_valid = r_ar_valid;
  assign m_ar_id    = {r_ar_src, r_ar_id};
  assign m_ar_pld   = r_ar_pld;

  // AW/AR control: load on acceptance, drop after downstream handshake,
  // hand priority to the other master after every win.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_valid <= 1'b0;
      r_aw_src   <= 1'b0;
      r_aw_ptr   <= 1'b0;
      r_ar_valid <= 1'b0;
      r_ar_src   <= 1'b0;
      r_ar_ptr   <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every register samples pre-edge values.
      if (|w_aw_hs) begin
        r_aw_valid <= 1'b1;
        r_aw_src   <= w_aw_hs[1];
        r_aw_ptr   <= !w_aw_hs[1];
      end else if (m_aw_ready) begin
        r_aw_valid <= 1'b0;
      end
      if (|w_ar_hs) begin
        r_ar_valid <= 1'b1;
        r_ar_src   <= w_ar_hs[1];
        r_ar_ptr   <= !w_ar_hs[1];
      end else if (m_ar_ready) begin
        r_ar_valid <= 1'b0;
      end
    end
  end

  // AW/AR payload capture from the accepted master.
  always_ff @(posedge clk_i) begin
    // NOTE: pure datapath storage is left unreset; it is only observed while
    // the matching valid/pointer state, which is reset, marks it as live.
    if (|w_aw_hs) begin
      r_aw_id  <= w_aw_hs[1] ? s_aw_id[ID_W +: ID_W] : s_aw_id[0 +: ID_W];
      r_aw_pld <= w_aw_hs[1] ? s_aw_pld[AW_PLD_W +: AW_PLD_W] : s_aw_pld[0 +: AW_PLD_W];
    end
    if (|w_ar_hs) begin
      r_ar_id  <= w_ar_hs[1] ? s_ar_id[ID_W +: ID_W] : s_ar_id[0 +: ID_W];
      r_ar_pld <= w_ar_hs[1] ? s_ar_pld[AR_PLD_W +: AR_PLD_W] : s_ar_pld[0 +: AR_PLD_W];
    end
  end

  // W routing FIFO: one source bit per accepted AW, popped on the last W beat.
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head       = r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign w_push       = |w_aw_hs;
  assign w_pop        = m_w_valid && m_w_ready && m_w_last;

  assign m_w_valid = !w_fifo_empty && s_w_valid[w_head];
  assign m_w_last  = s_w_last[w_head];
  assign m_w_pld   = w_head ? s_w_pld[W_PLD_W +: W_PLD_W] : s_w_pld[0 +: W_PLD_W];
  assign s_w_ready = {m_w_ready && !w_fifo_empty && w_head,
                      m_w_ready && !w_fifo_empty && !w_head};

  // W FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // W FIFO storage.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_aw_hs[1];
  end

  // B/R return steering by the prepended source bit.
  assign w_b_src   = m_b_id[ID_W];
  assign s_b_valid = {m_b_valid && w_b_src, m_b_valid && !w_b_src};
  assign m_b_ready = s_b_ready[w_b_src];
  assign s_b_id    = m_b_id[ID_W-1:0];
  assign s_b_pld   = m_b_pld;
  assign w_b_hs    = s_b_valid & s_b_ready;

  assign w_r_src   = m_r_id[ID_W];
  assign s_r_valid = {m_r_valid && w_r_src, m_r_valid && !w_r_src};
  assign m_r_ready = s_r_ready[w_r_src];
  assign s_r_id    = m_r_id[ID_W-1:0];
  assign s_r_pld   = m_r_pld;
  assign s_r_last  = m_r_last;
  assign w_r_done  = s_r_valid & s_r_ready & {2{m_r_last}};

  // Outstanding counters: request acceptance counts up, completion counts down.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_aw_hs[i] && !w_b_hs[i])      r_wcnt[i] <= r_wcnt[i] + CNT_W'(1);
        else if (!w_aw_hs[i] && w_b_hs[i]) r_wcnt[i] <= r_wcnt[i] - CNT_W'(1);
        if (w_ar_hs[i] && !w_r_done[i])      r_rcnt[i] <= r_rcnt[i] + CNT_W'(1);
        else if (!w_ar_hs[i] && w_r_done[i]) r_rcnt[i] <= r_rcnt[i] - CNT_W'(1);
      end
    end
  end

  // Protocol checks: no response for a master with nothing outstanding,
  // never two readies at once.
  a_b_solicited: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_b_valid && m_b_ready) |-> (r_wcnt[w_b_src] != '0));
  a_r_solicited: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_r_valid && m_r_ready) |-> (r_rcnt[w_r_src] != '0));
  a_aw_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    s_aw_ready != 2'b11);
  a_ar_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    s_ar_ready != 2'b11);

endmodule

// File: tb/tb_cva6_axi_mux2.sv
// Testbench for cva6_axi_mux2: directed scenarios for reset, round-robin,
// backpressure, W ordering and outstanding limits, followed by randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_cva6_axi_mux2;

  localparam int ID_W = 4;
  localparam int AW_W = 80;
  localparam int AR_W = 74;
  localparam int W_W  = 73;
  localparam int B_W  = 2;
  localparam int R_W  = 66;
  localparam int FD   = 4;
  localparam int MO   = 2;

  logic clk_i = 1'b0;
  logic rst_ni;

  logic [1:0]          s_aw_valid, s_aw_ready;
  logic [2*ID_W-1:0]   s_aw_id;
  logic [2*AW_W-1:0]   s_aw_pld;
  logic [1:0]          s_w_valid, s_w_last, s_w_ready;
  logic [2*W_W-1:0]    s_w_pld;
  logic [1:0]          s_b_valid, s_b_ready;
  logic [ID_W-1:0]     s_b_id;
  logic [B_W-1:0]      s_b_pld;
  logic [1:0]          s_ar_valid, s_ar_ready;
  logic [2*ID_W-1:0]   s_ar_id;
  logic [2*AR_W-1:0]   s_ar_pld;
  logic [1:0]          s_r_valid, s_r_ready;
  logic [ID_W-1:0]     s_r_id;
  logic [R_W-1:0]      s_r_pld;
  logic                s_r_last;
  logic                m_aw_valid, m_aw_ready;
  logic [ID_W:0]       m_aw_id;
  logic [AW_W-1:0]     m_aw_pld;
  logic                m_w_valid, m_w_ready, m_w_last;
  logic [W_W-1:0]      m_w_pld;
  logic                m_b_valid, m_b_ready;
  logic [ID_W:0]       m_b_id;
  logic [B_W-1:0]      m_b_pld;
  logic                m_ar_valid, m_ar_ready;
  logic [ID_W:0]       m_ar_id;
  logic [AR_W-1:0]     m_ar_pld;
  logic                m_r_valid, m_r_ready, m_r_last;
  logic [ID_W:0]       m_r_id;
  logic [R_W-1:0]      m_r_pld;

  cva6_axi_mux2 #(
    .ID_W(ID_W), .AW_PLD_W(AW_W), .AR_PLD_W(AR_W), .W_PLD_W(W_W),
    .B_PLD_W(B_W), .R_PLD_W(R_W), .W_FIFO_D(FD), .MAX_OUT(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_pld(s_aw_pld),
    .s_w_valid(s_w_valid), .s_w_last(s_w_last), .s_w_ready(s_w_ready), .s_w_pld(s_w_pld),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_pld(s_b_pld),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_pld(s_ar_pld),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_pld(s_r_pld),
    .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_pld(m_aw_pld),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_last(m_w_last), .m_w_pld(m_w_pld),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_pld(m_b_pld),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_pld(m_ar_pld),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_pld(m_r_pld),
    .m_r_last(m_r_last)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit              mdl_aw_v, mdl_ar_v, mdl_aw_src, mdl_ar_src;
  int              mdl_aw_ptr, mdl_ar_ptr;
  logic [ID_W-1:0] mdl_aw_id, mdl_ar_id;
  logic [AW_W-1:0] mdl_aw_pld;
  logic [AR_W-1:0] mdl_ar_pld;
  int              wcnt[2];
  int              rcnt[2];
  int              wq[$];     // source of each accepted AW still owing W beats

  task automatic model_reset();
    mdl_aw_v = 0; mdl_ar_v = 0; mdl_aw_src = 0; mdl_ar_src = 0;
    mdl_aw_ptr = 0; mdl_ar_ptr = 0;
    wcnt[0] = 0; wcnt[1] = 0; rcnt[0] = 0; rcnt[1] = 0;
    wq.delete();
  endtask

  function automatic int winner(input bit e0, input bit e1, input int ptr);
    if (e0 && e1) return ptr;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // Compare every DUT output with the model for the current inputs, then
  // advance the model by one clock.
  task automatic model_cycle();
    int aw_win, ar_win, head, bsrc, rsrc;
    logic [1:0] e_aw_rdy, e_ar_rdy, e_w_rdy, e_b_v, e_r_v;
    bit e_w_v;
    aw_win = winner(s_aw_valid[0] && wcnt[0] < MO && wq.size() < FD,
                    s_aw_valid[1] && wcnt[1] < MO && wq.size() < FD, mdl_aw_ptr);
    ar_win = winner(s_ar_valid[0] && rcnt[0] < MO, s_ar_valid[1] && rcnt[1] < MO, mdl_ar_ptr);
    e_aw_rdy = 2'b00;
    e_ar_rdy = 2'b00;
    if (aw_win >= 0 && (!mdl_aw_v || m_aw_ready)) e_aw_rdy[aw_win] = 1'b1;
    if (ar_win >= 0 && (!mdl_ar_v || m_ar_ready)) e_ar_rdy[ar_win] = 1'b1;
    check("s_aw_ready", s_aw_ready, e_aw_rdy);
    check("m_aw_valid", m_aw_valid, mdl_aw_v);
    if (mdl_aw_v) begin
      check("m_aw_id", m_aw_id, {mdl_aw_src, mdl_aw_id});
      check("m_aw_pld", m_aw_pld, mdl_aw_pld);
    end
    check("s_ar_ready", s_ar_ready, e_ar_rdy);
    check("m_ar_valid", m_ar_valid, mdl_ar_v);
    if (mdl_ar_v) begin
      check("m_ar_id", m_ar_id, {mdl_ar_src, mdl_ar_id});
      check("m_ar_pld", m_ar_pld, mdl_ar_pld);
    end
    head = (wq.size() > 0) ? wq[0] : 0;
    e_w_v = (wq.size() > 0) && s_w_valid[head];
    e_w_rdy = 2'b00;
    if (wq.size() > 0 && m_w_ready) e_w_rdy[head] = 1'b1;
    check("m_w_valid", m_w_valid, e_w_v);
    check("s_w_ready", s_w_ready, e_w_rdy);
    if (e_w_v) begin
      check("m_w_pld", m_w_pld, s_w_pld[head*W_W +: W_W]);
      check("m_w_last", m_w_last, s_w_last[head]);
    end
    bsrc = int'(m_b_id[ID_W]);
    e_b_v = 2'b00;
    if (m_b_valid) e_b_v[bsrc] = 1'b1;
    check("s_b_valid", s_b_valid, e_b_v);
    check("m_b_ready", m_b_ready, s_b_ready[bsrc]);
    if (m_b_valid) begin
      check("s_b_id", s_b_id, m_b_id[ID_W-1:0]);
      check("s_b_pld", s_b_pld, m_b_pld);
    end
    rsrc = int'(m_r_id[ID_W]);
    e_r_v = 2'b00;
    if (m_r_valid) e_r_v[rsrc] = 1'b1;
    check("s_r_valid", s_r_valid, e_r_v);
    check("m_r_ready", m_r_ready, s_r_ready[rsrc]);
    if (m_r_valid) begin
      check("s_r_id", s_r_id, m_r_id[ID_W-1:0]);
      check("s_r_pld", s_r_pld, m_r_pld);
      check("s_r_last", s_r_last, m_r_last);
    end
    // advance
    if (e_w_v && m_w_ready && s_w_last[head]) void'(wq.pop_front());
    if (e_aw_rdy != 2'b00) begin
      wq.push_back(aw_win);
      wcnt[aw_win]++;
      mdl_aw_v = 1; mdl_aw_src = aw_win[0]; mdl_aw_ptr = 1 - aw_win;
      mdl_aw_id = s_aw_id[aw_win*ID_W +: ID_W];
      mdl_aw_pld = s_aw_pld[aw_win*AW_W +: AW_W];
    end else if (m_aw_ready) mdl_aw_v = 0;
    if (e_ar_rdy != 2'b00) begin
      rcnt[ar_win]++;
      mdl_ar_v = 1; mdl_ar_src = ar_win[0]; mdl_ar_ptr = 1 - ar_win;
      mdl_ar_id = s_ar_id[ar_win*ID_W +: ID_W];
      mdl_ar_pld = s_ar_pld[ar_win*AR_W +: AR_W];
    end else if (m_ar_ready) mdl_ar_v = 0;
    if (m_b_valid && s_b_ready[bsrc]) wcnt[bsrc]--;
    if (m_r_valid && s_r_ready[rsrc] && m_r_last) rcnt[rsrc]--;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit rb(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic idle();
    s_aw_valid = '0; s_aw_id = '0; s_aw_pld = '0;
    s_w_valid = '0; s_w_last = '0; s_w_pld = '0;
    s_b_ready = '0;
    s_ar_valid = '0; s_ar_id = '0; s_ar_pld = '0;
    s_r_ready = '0;
    m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0;
    m_b_valid = 0; m_b_id = '0; m_b_pld = '0;
    m_r_valid = 0; m_r_id = '0; m_r_pld = '0; m_r_last = 0;
  endtask

  // Inputs are applied at the falling edge; settle, compare, advance.
  task automatic cycle();
    #1;
    model_cycle();
    @(negedge clk_i);
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic apply_reset();
    idle();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("rst_m_aw_valid", m_aw_valid, 1'b0);
    check("rst_m_ar_valid", m_ar_valid, 1'b0);
    check("rst_s_aw_ready", s_aw_ready, 2'b00);
    check("rst_s_ar_ready", s_ar_ready, 2'b00);
    check("rst_s_w_ready", s_w_ready, 2'b00);
    check("rst_m_w_valid", m_w_valid, 1'b0);
    check("rst_s_b_valid", s_b_valid, 2'b00);
    check("rst_s_r_valid", s_r_valid, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drive_random(input int p_aw, input int p_w, input int p_rdy, input int p_rsp);
    logic [127:0] a, b;
    int src;
    s_aw_valid = {rb(p_aw), rb(p_aw)};
    s_aw_id    = (2*ID_W)'($urandom);
    a = rnd128(); b = rnd128();
    s_aw_pld   = {a[AW_W-1:0], b[AW_W-1:0]};
    s_ar_valid = {rb(p_aw), rb(p_aw)};
    s_ar_id    = (2*ID_W)'($urandom);
    a = rnd128(); b = rnd128();
    s_ar_pld   = {a[AR_W-1:0], b[AR_W-1:0]};
    s_w_valid  = {rb(p_w), rb(p_w)};
    s_w_last   = 2'($urandom);
    a = rnd128(); b = rnd128();
    s_w_pld    = {a[W_W-1:0], b[W_W-1:0]};
    m_aw_ready = rb(p_rdy);
    m_ar_ready = rb(p_rdy);
    m_w_ready  = rb(p_rdy);
    s_b_ready  = {rb(p_rdy), rb(p_rdy)};
    s_r_ready  = {rb(p_rdy), rb(p_rdy)};
    // responses only for masters that have something outstanding
    m_b_valid = 0;
    src = $urandom_range(0, 1);
    if (wcnt[src] == 0) src = 1 - src;
    if (rb(p_rsp) && wcnt[src] > 0) begin
      m_b_valid = 1;
      m_b_id = {src[0], ID_W'($urandom)};
      m_b_pld = B_W'($urandom);
    end
    m_r_valid = 0;
    src = $urandom_range(0, 1);
    if (rcnt[src] == 0) src = 1 - src;
    if (rb(p_rsp) && rcnt[src] > 0) begin
      a = rnd128();
      m_r_valid = 1;
      m_r_id = {src[0], ID_W'($urandom)};
      m_r_pld = a[R_W-1:0];
      m_r_last = rb(50);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g0, g1, s0_beats, s1_beats;
    int order[$];
    logic [ID_W-1:0] held_id;
    logic [127:0]    held_pld;

    rst_ni = 1'b0;
    idle();
    @(negedge clk_i);
    apply_reset();

    // T1: reset in the middle of traffic, then a first AW from master 1
    for (int i = 0; i < 30; i++) begin
      drive_random(70, 60, 70, 40);
      cycle();
    end
    idle();
    s_aw_valid = 2'b01;
    cycle();                      // leaves the output register occupied
    apply_reset();
    s_aw_valid = 2'b10;
    s_aw_id = 8'h30;
    m_aw_ready = 1'b1;
    cycle();
    idle();
    #1;
    check("t1_m_aw_valid", m_aw_valid, 1'b1);
    check("t1_m_aw_id", m_aw_id, 5'h13);
    cycle();

    // T2: both masters request every cycle; grants alternate starting at 0
    apply_reset();
    g0 = 0; g1 = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      s_aw_valid = 2'b11;
      s_aw_id = (2*ID_W)'($urandom);
      m_aw_ready = 1'b1;
      s_w_valid = 2'b11; s_w_last = 2'b11; m_w_ready = 1'b1;
      s_b_ready = 2'b11;
      if (k > 0) begin
        m_b_valid = 1'b1;
        m_b_id = {((k - 1) % 2) == 1, 4'h0};
      end
      #1;
      check("t2_grant", s_aw_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (s_aw_ready[0]) g0++;
      if (s_aw_ready[1]) g1++;
      cycle();
    end
    check("t2_grants_m0", g0, 4);
    check("t2_grants_m1", g1, 4);

    // T3: downstream stall holds the request register stable
    apply_reset();
    held_id = 4'hA;
    held_pld = rnd128();
    s_aw_valid = 2'b01;
    s_aw_id = {4'h0, held_id};
    s_aw_pld = {80'h0, held_pld[AW_W-1:0]};
    cycle();
    for (int k = 0; k < 5; k++) begin
      idle();
      s_aw_valid = 2'b11;
      s_aw_id = (2*ID_W)'($urandom);
      s_aw_pld = {rnd128(), rnd128()};
      #1;
      check("t3_s_aw_ready", s_aw_ready, 2'b00);
      check("t3_m_aw_id", m_aw_id, {1'b0, held_id});
      check("t3_m_aw_pld", m_aw_pld, held_pld[AW_W-1:0]);
      cycle();
    end
    idle();
    m_aw_ready = 1'b1;
    cycle();

    // T4: W follows AW order: 4 beats of master 1, then 1 beat of master 0
    apply_reset();
    s1_beats = 0; s0_beats = 0;
    order.delete();
    for (int c = 0; c < 10; c++) begin
      idle();
      s_aw_valid = (c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00;
      m_aw_ready = 1'b1;
      s_w_valid = {s1_beats < 4, s0_beats < 1};
      s_w_last = {s1_beats == 3, 1'b1};
      s_w_pld = {rnd128(), rnd128()};
      m_w_ready = 1'b1;
      #1;
      if (m_w_valid && s_w_ready[1]) begin s1_beats++; order.push_back(1); end
      if (m_w_valid && s_w_ready[0]) begin s0_beats++; order.push_back(0); end
      cycle();
    end
    check("t4_beats", order.size(), 5);
    for (int i = 0; i < order.size(); i++) check("t4_beat_src", order[i], (i < 4) ? 1 : 0);

    // T5: outstanding limit of 2 on master 0, released by one B
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      s_aw_valid = 2'b01;
      s_aw_id = 8'h02;
      m_aw_ready = 1'b1;
      #1;
      check("t5_aw_ready", s_aw_ready, (k < 2) ? 2'b01 : 2'b00);
      cycle();
    end
    s_aw_valid = 2'b01; s_aw_id = 8'h02; m_aw_ready = 1'b1;
    m_b_valid = 1'b1; m_b_id = 5'h02; s_b_ready = 2'b01;
    #1;
    check("t5_s_b_valid", s_b_valid, 2'b01);
    check("t5_s_b_id", s_b_id, 4'h2);
    check("t5_aw_still_blocked", s_aw_ready, 2'b00);
    cycle();
    m_b_valid = 1'b0; s_b_ready = 2'b00;
    #1;
    check("t5_aw_released", s_aw_ready, 2'b01);
    cycle();

    // Randomized traffic under several load profiles
    apply_reset();
    for (int i = 0; i < 600; i++) begin drive_random(70, 70, 70, 40); cycle(); end
    for (int i = 0; i < 600; i++) begin drive_random(90, 10, 80, 30); cycle(); end
    for (int i = 0; i < 600; i++) begin drive_random(50, 90, 20, 60); cycle(); end
    for (int i = 0; i < 600; i++) begin drive_random(90, 90, 100, 50); cycle(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
